// File: rtl/apb_cmd_pkg.sv
// Shared types and default widths for the APB command master.
package apb_cmd_pkg;

    localparam int APB_ADDR_W = 32;
    localparam int APB_DATA_W = 32;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } apb_state_t;

endpackage

// File: rtl/apb_timeout_cnt.sv
// ACCESS-phase wait counter; terminal is high while the count sits on the last
// permitted wait cycle, so the caller aborts on that edge.
module apb_timeout_cnt #(
    parameter int LIMIT = 64
) (
    input  logic FCLK_CLK1,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic terminal
);

    localparam int CNT_W = $clog2(LIMIT + 1);

    logic [CNT_W-1:0] count;

    always_ff @(posedge FCLK_CLK1) begin
        if (rst || clear) begin
            count <= '0;
        end else if (enable) begin
            count <= count + CNT_W'(1);
        end
    end

    assign terminal = (count == CNT_W'(LIMIT - 1));

endmodule

// File: rtl/apb_cmd_master.sv
// Valid/ready command port to APB3 initiator, one transfer outstanding.
// Optional ACCESS-phase timeout with timeout_flag output: define APB_TIMEOUT_EN.
module apb_cmd_master
    import apb_cmd_pkg::*;
#(
    parameter int ADDR_W = APB_ADDR_W,
    parameter int DATA_W = APB_DATA_W
`ifdef APB_TIMEOUT_EN
    ,
    parameter int TIMEOUT_CYCLES = 64
`endif
) (
    input  logic              FCLK_CLK1,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic [ADDR_W-1:0] APB_M_0_paddr,
    output logic              APB_M_0_psel,
    output logic              APB_M_0_penable,
    output logic              APB_M_0_pwrite,
    output logic [DATA_W-1:0] APB_M_0_pwdata,
    input  logic [DATA_W-1:0] APB_M_0_prdata,
    input  logic              APB_M_0_pready,
    input  logic              APB_M_0_pslverr
`ifdef APB_TIMEOUT_EN
    ,
    output logic              timeout_flag
`endif
);

    apb_state_t state;
    apb_state_t next_state;
    logic       accept;
    logic       complete;

`ifdef APB_TIMEOUT_EN
    logic timeout_hit;
    logic cnt_terminal;
    logic timed_out;

    apb_timeout_cnt #(
        .LIMIT(TIMEOUT_CYCLES)
    ) u_timeout_cnt (
        .FCLK_CLK1 (FCLK_CLK1),
        .rst       (rst),
        .clear     (state == SETUP),
        .enable    ((state == ACCESS) && !APB_M_0_pready),
        .terminal  (cnt_terminal)
    );
`endif

    always_ff @(posedge FCLK_CLK1) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // A pready arriving on the terminal-count edge takes priority over the timeout.
    always_comb begin
        next_state = state;
        accept     = 1'b0;
        complete   = 1'b0;
`ifdef APB_TIMEOUT_EN
        timeout_hit = 1'b0;
`endif
        case (state)
            IDLE: begin
                if (cmd_valid) begin
                    accept     = 1'b1;
                    next_state = SETUP;
                end
            end
            SETUP: begin
                next_state = ACCESS;
            end
            ACCESS: begin
                if (APB_M_0_pready) begin
                    complete   = 1'b1;
                    next_state = RESP;
                end
`ifdef APB_TIMEOUT_EN
                else if (cnt_terminal) begin
                    timeout_hit = 1'b1;
                    next_state  = RESP;
                end
`endif
            end
            RESP: begin
                next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    assign cmd_ready = (state == IDLE);

    // Bus strobes follow the next state so they are registered and glitch-free.
    always_ff @(posedge FCLK_CLK1) begin
        if (rst) begin
            APB_M_0_psel    <= 1'b0;
            APB_M_0_penable <= 1'b0;
            APB_M_0_paddr   <= '0;
            APB_M_0_pwrite  <= 1'b0;
            APB_M_0_pwdata  <= '0;
            rsp_valid       <= 1'b0;
            rsp_rdata       <= '0;
            rsp_err         <= 1'b0;
        end else begin
            APB_M_0_psel    <= (next_state == SETUP) || (next_state == ACCESS);
            APB_M_0_penable <= (next_state == ACCESS);
            rsp_valid       <= (state == RESP);
            if (accept) begin
                APB_M_0_paddr  <= cmd_addr;
                APB_M_0_pwrite <= cmd_write;
                APB_M_0_pwdata <= cmd_wdata;
            end
            if (complete) begin
                rsp_rdata <= APB_M_0_pwrite ? '0 : APB_M_0_prdata;
                rsp_err   <= APB_M_0_pslverr;
            end
`ifdef APB_TIMEOUT_EN
            if (timeout_hit) begin
                rsp_rdata <= '0;
                rsp_err   <= 1'b1;
            end
`endif
        end
    end

`ifdef APB_TIMEOUT_EN
    always_ff @(posedge FCLK_CLK1) begin
        if (rst) begin
            timed_out    <= 1'b0;
            timeout_flag <= 1'b0;
        end else begin
            timeout_flag <= (state == RESP) && timed_out;
            if (timeout_hit) begin
                timed_out <= 1'b1;
            end else if (complete) begin
                timed_out <= 1'b0;
            end
        end
    end
`endif

endmodule
